niosii_system_sysid_ext: RTL
============================

Name: niosII_system_sysid_ext

Overview:
- Parametrised successor to the Qsys system-ID slave, on the same Avalon-MM control bus of the Nios II system.
- Returns a build ID and build timestamp, as before, and adds:
  - a capability word;
  - a 64-bit free-running uptime cycle counter with coherent high-word snapshot;
  - a seconds counter derived from a prescaler;
  - NUM_SCRATCH read/write scratch registers for software bring-up.
- Registered read path: fixed read latency of 1, with readdatavalid.

Parameters:
- ID_VALUE, 32'h0000_0000, value returned at word 0.
- TIMESTAMP_VALUE, 32'd1486768958, build epoch seconds returned at word 1.
- NUM_SCRATCH, 2, number of scratch registers, range 1..8.
- CLK_FREQ_HZ, 50000000, clock cycles per second; sets the prescaler terminal count.
- ADDR_WIDTH, 4, word address width. Must satisfy 6+NUM_SCRATCH <= 2**ADDR_WIDTH.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  ADDR_WIDTH  word address.
- read  in  1  read strobe, single cycle.
- write  in  1  write strobe, single cycle.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- readdatavalid  out  1  one-cycle pulse; readdata is valid in that cycle.

Behaviour:
- Reset (reset=1 at a clock edge) sets all of the following to 0 on that edge; takes priority over everything:
  - readdata, readdatavalid;
  - uptime counter, hi snapshot, prescaler, seconds counter;
  - all scratch registers.
- Register map (word address):
  - 0 ID: RO, ID_VALUE.
  - 1 TIMESTAMP: RO, TIMESTAMP_VALUE.
  - 2 CAPS/CTRL, read: [7:0]=NUM_SCRATCH, [15:8]=8'h02 (block version), [31:16]=0.
  - 2 CAPS/CTRL, write: writedata[0]=1 clears uptime, prescaler and seconds on the next edge. Self-clearing; other bits ignored.
  - 3 UPTIME_LO: RO, current uptime[31:0]. The same read edge loads the hi snapshot with uptime[63:32].
  - 4 UPTIME_HI: RO, hi snapshot value (not the live counter).
  - 5 SECONDS: RO, seconds counter.
  - 6..6+NUM_SCRATCH-1 SCRATCH[n]: RW, full 32-bit write.
  - Unmapped addresses: read 0, writes ignored. readdatavalid is still returned for reads.
- Read timing:
  - read=1 at edge N → readdata valid and readdatavalid=1 at edge N+1.
  - readdatavalid=0 otherwise; readdata holds its last value when not valid.
  - Back-to-back reads on consecutive cycles are supported (throughput 1/cycle).
- Write timing: takes effect at the sampling edge. A read on the next cycle returns the new value.
- read and write both 1 in the same cycle: the write is performed, the read is dropped, and no readdatavalid is issued.
- Uptime counter:
  - 64-bit, +1 every cycle.
  - Wraps from 2**64-1 to 0.
  - The value returned for a UPTIME_LO read is the counter value before that edge's increment.
- Prescaler:
  - Counts 0..CLK_FREQ_HZ-1, width $clog2(CLK_FREQ_HZ).
  - At terminal count it returns to 0 and SECONDS increments.
  - SECONDS is 32-bit and wraps to 0.
- Clear via CTRL write:
  - Uptime, prescaler and SECONDS go to 0 on that edge; the hi snapshot is unchanged.
  - Clear wins over increment in the same edge.
  - The first cycle after a clear reads uptime=0.

Decomposition:
- Shared package niosII_system_sysid_pkg holds:
  - register-offset localparams: ADDR_ID=0, ADDR_TS=1, ADDR_CTRL=2, ADDR_UP_LO=3, ADDR_UP_HI=4, ADDR_SEC=5, ADDR_SCR0=6;
  - SYSID_VERSION=8'h02;
  - CTRL_CLR_BIT=0.
- One sub-module: niosII_system_sysid_uptime.
  - Contains the 64-bit counter, prescaler and seconds counter.
  - Inputs: clear and snapshot strobe.
  - Outputs: lo, hi snapshot and seconds.
- The top level holds address decode, the scratch array and the read register.

Test Plan:
- Reset, then read addresses 0, 1, 2 on consecutive cycles → readdatavalid pulses on 3 consecutive cycles, returning 0, 1486768958, 32'h0000_0202.
- Write 32'hDEADBEEF to 6 and 32'h12345678 to 7, then read 6, 7, 9 → returns DEADBEEF, 12345678, 0. Write to 1 is ignored; a following read of 1 still returns TIMESTAMP_VALUE.
- Preload the uptime counter to 64'h0000_0001_FFFF_FFFE via the hierarchical force/TB hook; read 3 two cycles later, then 4 → read 3 returns 32'h0000_0000, read 4 returns 32'h0000_0002, consistent with the 64-bit value 64'h0000_0002_0000_0000 sampled at that read.
- With CLK_FREQ_HZ=10: run 35 cycles after reset, read 5 → returns 3. Write 1 to address 2, read 3 next cycle → returns 0; read 5 → returns 0.
- Assert read and write together at address 6 with writedata 5 → no readdatavalid. A subsequent read of 6 returns 5.
- Assert reset mid-operation, with a read in flight and scratch at 32'hDEADBEEF → next edge: readdatavalid=0, readdata=0. Reads of 6 and 3 afterwards return 0 and a small cycle count.

Source files
------------

// File: rtl/niosii_system_sysid_pkg.sv
// Shared register map and constants for the extended system-ID slave.
package niosii_system_sysid_pkg;

    localparam int unsigned ADDR_ID     = 0;
    localparam int unsigned ADDR_TS     = 1;
    localparam int unsigned ADDR_CTRL   = 2;
    localparam int unsigned ADDR_UP_LO  = 3;
    localparam int unsigned ADDR_UP_HI  = 4;
    localparam int unsigned ADDR_SEC    = 5;
    localparam int unsigned ADDR_SCR0   = 6;

    localparam logic [7:0]  SYSID_VERSION = 8'h02;
    localparam int unsigned CTRL_CLR_BIT  = 0;

    function automatic logic [31:0] caps_word(input int unsigned num_scratch);
        logic [31:0] n;
        n = num_scratch;
        return {16'h0000, SYSID_VERSION, n[7:0]};
    endfunction

endpackage

// File: rtl/niosii_system_sysid_uptime.sv
// 64-bit uptime counter with coherent high-word snapshot, plus prescaled seconds counter.
module niosii_system_sysid_uptime #(
    parameter int unsigned CLK_FREQ_HZ = 50000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        snap,
    output logic [31:0] lo,
    output logic [31:0] hi,
    output logic [31:0] seconds
);

    localparam int unsigned PresW = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam logic [PresW-1:0] PresTc = PresW'(CLK_FREQ_HZ - 1);

    logic [63:0]      cnt_q;
    logic [63:0]      cnt_d;
    logic [PresW-1:0] presc_q, presc_d;
    logic [31:0]      sec_q, sec_d;
    logic [31:0]      hi_q;

    // Kept as a continuous assignment so the next-state can be overridden externally.
    assign cnt_d = clear ? 64'd0 : cnt_q + 64'd1;

    always_comb begin
        presc_d = presc_q + PresW'(1);
        sec_d   = sec_q;
        if (presc_q == PresTc) begin
            presc_d = '0;
            sec_d   = sec_q + 32'd1;
        end
        if (clear) begin
            presc_d = '0;
            sec_d   = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            presc_q <= '0;
            sec_q   <= '0;
            hi_q    <= '0;
        end else begin
            cnt_q   <= cnt_d;
            presc_q <= presc_d;
            sec_q   <= sec_d;
            // Snapshot uses the pre-increment value so lo/hi form one coherent sample.
            if (snap) begin
                hi_q <= cnt_q[63:32];
            end
        end
    end

    assign lo      = cnt_q[31:0];
    assign hi      = hi_q;
    assign seconds = sec_q;

endmodule

// File: rtl/niosii_system_sysid_ext.sv
// Extended system-ID Avalon-MM slave: ID, timestamp, caps/ctrl, uptime, seconds, scratch.
module niosii_system_sysid_ext #(
    parameter logic [31:0] ID_VALUE        = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP_VALUE = 32'd1486768958,
    parameter int unsigned NUM_SCRATCH     = 2,
    parameter int unsigned CLK_FREQ_HZ     = 50000000,
    parameter int unsigned ADDR_WIDTH      = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  read,
    input  logic                  write,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic                  readdatavalid
);

    import niosii_system_sysid_pkg::*;

    logic [31:0] addr_w;
    logic        rd_en;
    logic        clr;
    logic        snap;
    logic [31:0] up_lo, up_hi, seconds;
    logic [31:0] rdata_d;
    logic [31:0] scratch_q [NUM_SCRATCH];

    assign addr_w = 32'(address);
    // A simultaneous write wins; the read is dropped entirely.
    assign rd_en  = read & ~write;
    assign clr    = write & (addr_w == ADDR_CTRL) & writedata[CTRL_CLR_BIT];
    assign snap   = rd_en & (addr_w == ADDR_UP_LO);

    niosii_system_sysid_uptime #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ)
    ) u_uptime (
        .clock  (clock),
        .reset  (reset),
        .clear  (clr),
        .snap   (snap),
        .lo     (up_lo),
        .hi     (up_hi),
        .seconds(seconds)
    );

    always_comb begin
        rdata_d = '0;
        unique case (addr_w)
            ADDR_ID:    rdata_d = ID_VALUE;
            ADDR_TS:    rdata_d = TIMESTAMP_VALUE;
            ADDR_CTRL:  rdata_d = caps_word(NUM_SCRATCH);
            ADDR_UP_LO: rdata_d = up_lo;
            ADDR_UP_HI: rdata_d = up_hi;
            ADDR_SEC:   rdata_d = seconds;
            default: begin
                for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
                    if (addr_w == ADDR_SCR0 + i) begin
                        rdata_d = scratch_q[i];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
                scratch_q[i] <= '0;
            end
        end else if (write) begin
            for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
                if (addr_w == ADDR_SCR0 + i) begin
                    scratch_q[i] <= writedata;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            readdata      <= '0;
            readdatavalid <= 1'b0;
        end else begin
            readdatavalid <= rd_en;
            if (rd_en) begin
                readdata <= rdata_d;
            end
        end
    end

endmodule
